// File: rtl/if_id_stage.sv
// IF/ID pipeline stage: owns the fetch PC, the IF/ID instruction latch,
// the sticky HALT freeze and a saturating stall-cycle counter.
// Per-cycle priority for the PC and IF/ID registers is
// flush > halted > hold > advance.
module if_id_stage #(
    parameter logic [15:0] NOP_INSTR = 16'h0800,
    parameter logic [4:0]  HALT_OPC  = 5'b00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr_in,
    input  logic [15:0] pc_inc,
    input  logic [15:0] redirect_pc,
    input  logic        flush,
    input  logic        stall,
    input  logic        stage_wr_en,
    output logic [15:0] pc_out,
    output logic [15:0] if_id_instr,
    output logic [15:0] if_id_pc2,
    output logic        if_id_valid,
    output logic        bubble,
    output logic        halted,
    output logic [15:0] stall_cnt
);

    logic        hold;
    logic        is_halt_opc;

    logic [15:0] pc_q,          pc_d;
    logic [15:0] if_id_instr_q, if_id_instr_d;
    logic [15:0] if_id_pc2_q,   if_id_pc2_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic        halted_q,      halted_d;
    logic [15:0] stall_cnt_q,   stall_cnt_d;

    // Either a RAW stall or a deasserted write enable freezes the stage.
    assign hold        = stall | ~stage_wr_en;
    assign is_halt_opc = (instr_in[15:11] == HALT_OPC);

    // Next-state selection for the PC and IF/ID registers and the halt flag.
    always_comb begin
        pc_d          = pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_pc2_d   = if_id_pc2_q;
        if_id_valid_d = if_id_valid_q;
        halted_d      = halted_q;

        if (flush) begin
            // Redirect wins over everything, including hold and halt.
            pc_d          = redirect_pc;
            if_id_instr_d = NOP_INSTR;
            if_id_pc2_d   = redirect_pc;
            if_id_valid_d = 1'b0;
            halted_d      = 1'b0;
        end else if (halted_q) begin
            // Fetch frozen; drain IF/ID to a NOP unless decode is holding it.
            if (!hold) begin
                if_id_instr_d = NOP_INSTR;
                if_id_valid_d = 1'b0;
            end
        end else if (hold) begin
            // Everything keeps its value.
        end else begin
            pc_d          = pc_inc;
            if_id_instr_d = instr_in;
            if_id_pc2_d   = pc_inc;
            if_id_valid_d = 1'b1;
            // The HALT itself still moves the PC on this edge only.
            if (is_halt_opc) begin
                halted_d = 1'b1;
            end
        end
    end

    // Saturating count of held (non-flush) cycles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hold && !flush && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= 16'h0000;
            if_id_instr_q <= NOP_INSTR;
            if_id_pc2_q   <= 16'h0000;
            if_id_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            stall_cnt_q   <= 16'h0000;
        end else begin
            pc_q          <= pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pc2_q   <= if_id_pc2_d;
            if_id_valid_q <= if_id_valid_d;
            halted_q      <= halted_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign pc_out      = pc_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_pc2   = if_id_pc2_q;
    assign if_id_valid = if_id_valid_q;
    assign halted      = halted_q;
    assign stall_cnt   = stall_cnt_q;
    // Combinational so ID/EX sees the bubble in the same cycle.
    assign bubble      = stall | ~if_id_valid_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: the driver pushes hand-computed
// expected outputs after each edge; a negedge monitor pops and compares.
module tb_if_id_stage;

    logic        clk;
    logic        rst;
    logic [15:0] instr_in;
    logic [15:0] pc_inc;
    logic [15:0] redirect_pc;
    logic        flush;
    logic        stall;
    logic        stage_wr_en;
    logic [15:0] pc_out;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc2;
    logic        if_id_valid;
    logic        bubble;
    logic        halted;
    logic [15:0] stall_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        string       name;
        logic [15:0] pc;
        logic [15:0] ins;
        logic [15:0] pc2;
        logic        v;
        logic        b;
        logic        h;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    if_id_stage #(
        .NOP_INSTR(16'h0800),
        .HALT_OPC (5'b00000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .instr_in   (instr_in),
        .pc_inc     (pc_inc),
        .redirect_pc(redirect_pc),
        .flush      (flush),
        .stall      (stall),
        .stage_wr_en(stage_wr_en),
        .pc_out     (pc_out),
        .if_id_instr(if_id_instr),
        .if_id_pc2  (if_id_pc2),
        .if_id_valid(if_id_valid),
        .bubble     (bubble),
        .halted     (halted),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string nm, input string fld,
                       input logic [15:0] act, input logic [15:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("[TB] FAIL %s.%s got=%h expected=%h", nm, fld, act, req);
        end
    endtask

    // Monitor: outputs are presented every cycle; check on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp(e.name, "pc_out",      pc_out,              e.pc);
            cmp(e.name, "if_id_instr", if_id_instr,         e.ins);
            cmp(e.name, "if_id_pc2",   if_id_pc2,           e.pc2);
            cmp(e.name, "if_id_valid", {15'd0, if_id_valid}, {15'd0, e.v});
            cmp(e.name, "bubble",      {15'd0, bubble},      {15'd0, e.b});
            cmp(e.name, "halted",      {15'd0, halted},      {15'd0, e.h});
            cmp(e.name, "stall_cnt",   stall_cnt,           e.cnt);
            $display("[TB] %-14s pc=%h ins=%h pc2=%h v=%b b=%b h=%b cnt=%h",
                     e.name, pc_out, if_id_instr, if_id_pc2,
                     if_id_valid, bubble, halted, stall_cnt);
        end
    end

    task automatic push_exp(input string nm, input logic [15:0] pc,
                            input logic [15:0] ins, input logic [15:0] pc2,
                            input logic v, input logic b, input logic h,
                            input logic [15:0] cnt);
        exp_t e;
        e.name = nm; e.pc = pc; e.ins = ins; e.pc2 = pc2;
        e.v = v; e.b = b; e.h = h; e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    // One edge with the current inputs, then queue the expected state.
    // Returns just after the following negedge so new inputs never race the monitor.
    task automatic cyc(input string nm, input logic [15:0] pc,
                       input logic [15:0] ins, input logic [15:0] pc2,
                       input logic v, input logic b, input logic h,
                       input logic [15:0] cnt);
        @(posedge clk);
        #1;
        push_exp(nm, pc, ins, pc2, v, b, h, cnt);
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] pinc, input logic [15:0] ins,
                         input logic st, input logic we, input logic fl,
                         input logic [15:0] rpc);
        pc_inc = pinc; instr_in = ins; stall = st;
        stage_wr_en = we; flush = fl; redirect_pc = rpc;
    endtask

    initial begin
        rst = 1'b1;
        drive(16'h0002, 16'h4123, 1'b1, 1'b1, 1'b0, 16'h0000);
        #1;
        push_exp("reset", 16'h0000, 16'h0800, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000);
        @(negedge clk);
        #1;

        // Reset then run
        rst = 1'b0;
        drive(16'h0002, 16'h4123, 1'b0, 1'b1, 1'b0, 16'h0000);
        cyc("run1", 16'h0002, 16'h4123, 16'h0002, 1'b1, 1'b0, 1'b0, 16'h0000);
        drive(16'h0004, 16'h5200, 1'b0, 1'b1, 1'b0, 16'h0000);
        cyc("run2", 16'h0004, 16'h5200, 16'h0004, 1'b1, 1'b0, 1'b0, 16'h0000);

        // Stall hold for 3 edges, HALT opcode present but held
        drive(16'h0006, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000);
        cyc("hold1", 16'h0004, 16'h5200, 16'h0004, 1'b1, 1'b1, 1'b0, 16'h0001);
        cyc("hold2", 16'h0004, 16'h5200, 16'h0004, 1'b1, 1'b1, 1'b0, 16'h0002);
        cyc("hold3", 16'h0004, 16'h5200, 16'h0004, 1'b1, 1'b1, 1'b0, 16'h0003);

        // Flush over stall
        drive(16'h0006, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0040);
        cyc("flush_stall", 16'h0040, 16'h0800, 16'h0040, 1'b0, 1'b1, 1'b0, 16'h0003);

        // Advance to pc 0x0010, then HALT
        drive(16'h0010, 16'h6001, 1'b0, 1'b1, 1'b0, 16'h0000);
        cyc("adv10", 16'h0010, 16'h6001, 16'h0010, 1'b1, 1'b0, 1'b0, 16'h0003);
        drive(16'h0012, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000);
        cyc("halt", 16'h0012, 16'h0000, 16'h0012, 1'b1, 1'b0, 1'b1, 16'h0003);
        drive(16'h0014, 16'h7777, 1'b0, 1'b1, 1'b0, 16'h0000);
        for (int i = 0; i < 5; i++) begin
            cyc("halted_frz", 16'h0012, 16'h0800, 16'h0012, 1'b0, 1'b1, 1'b1, 16'h0003);
        end
        drive(16'h0014, 16'h7777, 1'b1, 1'b1, 1'b0, 16'h0000);
        cyc("halted_hold", 16'h0012, 16'h0800, 16'h0012, 1'b0, 1'b1, 1'b1, 16'h0004);

        // Flush out of halt, HALT opcode ignored under flush
        drive(16'h0014, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0100);
        cyc("flush_halt", 16'h0100, 16'h0800, 16'h0100, 1'b0, 1'b1, 1'b0, 16'h0004);
        drive(16'h0102, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0104);
        cyc("flush_hopc", 16'h0104, 16'h0800, 16'h0104, 1'b0, 1'b1, 1'b0, 16'h0004);
        drive(16'h0106, 16'h3333, 1'b0, 1'b1, 1'b0, 16'h0000);
        cyc("adv106", 16'h0106, 16'h3333, 16'h0106, 1'b1, 1'b0, 1'b0, 16'h0004);

        // Saturation: hold until the counter is at FFFB, then check the top
        drive(16'h0108, 16'h4444, 1'b1, 1'b1, 1'b0, 16'h0000);
        repeat (65527) @(posedge clk);
        @(negedge clk);
        #1;
        cyc("sat_fffc", 16'h0106, 16'h3333, 16'h0106, 1'b1, 1'b1, 1'b0, 16'hFFFC);
        cyc("sat_fffd", 16'h0106, 16'h3333, 16'h0106, 1'b1, 1'b1, 1'b0, 16'hFFFD);
        cyc("sat_fffe", 16'h0106, 16'h3333, 16'h0106, 1'b1, 1'b1, 1'b0, 16'hFFFE);
        cyc("sat_ffff", 16'h0106, 16'h3333, 16'h0106, 1'b1, 1'b1, 1'b0, 16'hFFFF);
        cyc("sat_hold", 16'h0106, 16'h3333, 16'h0106, 1'b1, 1'b1, 1'b0, 16'hFFFF);

        // Async reset between edges, mid-stall
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        push_exp("async_rst", 16'h0000, 16'h0800, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000);
        @(negedge clk);
        #1;

        // First edge after release is a normal advance
        rst = 1'b0;
        drive(16'h0002, 16'h1234, 1'b0, 1'b1, 1'b0, 16'h0000);
        cyc("post_rst", 16'h0002, 16'h1234, 16'h0002, 1'b1, 1'b0, 1'b0, 16'h0000);

        // Let the monitor drain, bounded
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL drain pending=%0d expected=0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 The block SHALL have parameter NOP_INSTR, default 16'h0800, which is the encoding loaded into IF/ID on reset or flush.
REQ-002 The block SHALL have parameter HALT_OPC, default 5'b00000, which is the opcode (instr[15:11]) that freezes fetch.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port instr_in, input, 16 bits: the instruction fetched at pc_out.
REQ-006 The block SHALL have port pc_inc, input, 16 bits: pc_out+2 from the fetch adder.
REQ-007 The block SHALL have port redirect_pc, input, 16 bits: the branch or jump target from EX.
REQ-008 The block SHALL have port flush, input, 1 bit: a taken-branch redirect that squashes the wrong-path fetch.
REQ-009 The block SHALL have port stall, input, 1 bit: RAW stall from hazard detection.
REQ-010 The block SHALL have port stage_wr_en, input, 1 bit: IF/ID and PC write enable from hazard detection.
REQ-011 The block SHALL have port pc_out, output, 16 bits: the current fetch PC.
REQ-012 The block SHALL have port if_id_instr, output, 16 bits: the instruction latched for decode.
REQ-013 The block SHALL have port if_id_pc2, output, 16 bits: pc_inc latched with if_id_instr.
REQ-014 The block SHALL have port if_id_valid, output, 1 bit: IF/ID holds a real instruction.
REQ-015 The block SHALL have port bubble, output, 1 bit: forces ID/EX control signals to zero this cycle.
REQ-016 The block SHALL have port halted, output, 1 bit: sticky flag indicating fetch is frozen on HALT.
REQ-017 The block SHALL have port stall_cnt, output, 16 bits: count of stalled cycles for performance counting.

Function
REQ-018 The block SHALL compute hold = stall | ~stage_wr_en, so that either input alone holds the stage.
REQ-019 The block SHALL apply per-cycle priority flush > halted > hold > advance to the PC and IF/ID registers.
REQ-020 On flush, the block SHALL load pc_out <= redirect_pc, if_id_instr <= NOP_INSTR, if_id_pc2 <= redirect_pc and if_id_valid <= 0, and SHALL clear halted, even when hold=1.
REQ-021 When halted=1 and flush=0, the block SHALL keep pc_out unchanged and load if_id_instr <= NOP_INSTR with if_id_valid <= 0, unless hold=1, in which case IF/ID SHALL also hold.
REQ-022 When hold=1 with no flush and not halted, the block SHALL keep pc_out, if_id_instr, if_id_pc2 and if_id_valid unchanged.
REQ-023 On advance, the block SHALL load pc_out <= pc_inc, if_id_instr <= instr_in, if_id_pc2 <= pc_inc and if_id_valid <= 1.
REQ-024 On advance with instr_in[15:11] == HALT_OPC, the block SHALL set halted <= 1, and pc_out SHALL still take pc_inc on that edge only.
REQ-025 The block SHALL NOT set halted when a HALT opcode is present on instr_in during a flush or hold cycle.
REQ-026 The block SHALL drive bubble = stall | ~if_id_valid combinationally, with no added latency.
REQ-027 stall_cnt SHALL increment by 1 on each edge where hold=1 and flush=0, and SHALL saturate at 16'hFFFF with no wrap.
REQ-028 The block SHALL have a one-cycle latency from instr_in to if_id_instr and no other pipeline delay.

Reset
REQ-029 On rst, asynchronously and regardless of clk, the block SHALL set pc_out=16'h0000, if_id_instr=NOP_INSTR, if_id_pc2=16'h0000, if_id_valid=0, halted=0 and stall_cnt=0.
REQ-030 While rst=1, the block SHALL ignore all other inputs, and bubble SHALL read 1.
REQ-031 Reset asserted mid-stall or while halted SHALL fully return the block to the REQ-029 state, and the first edge after deassertion SHALL be a normal advance.

Verification
REQ-032 The bench SHALL check reset-then-run: release rst with pc_inc=2 and instr_in=16'h4123, then after 1 edge expect pc_out=2, if_id_instr=16'h4123, if_id_valid=1 and bubble=0.
REQ-033 The bench SHALL check a stall hold: stall=1 and stage_wr_en=0 for 3 edges, then expect pc_out and if_id_instr unchanged, bubble=1 and stall_cnt=3.
REQ-034 The bench SHALL check flush over stall: flush=1, stall=1 and redirect_pc=16'h0040 on the same edge, then expect pc_out=16'h0040, if_id_instr=16'h0800, if_id_valid=0 and stall_cnt unchanged.
REQ-035 The bench SHALL check HALT: advance with instr_in=16'h0000 at pc 16'h0010, then expect halted=1, pc_out=16'h0012 frozen for 5 further edges, and if_id_valid=0 after the next edge.
REQ-036 The bench SHALL check flush out of halt: from halted, flush=1 with redirect_pc=16'h0100, then expect halted=0 and pc_out=16'h0100; on the next advance with instr_in=16'h0000 under flush, expect halted to stay 0.
REQ-037 The bench SHALL check saturation and async reset: preload stall_cnt near 16'hFFFF and hold for 4 edges, then expect 16'hFFFF; then assert rst between edges and expect all outputs at their reset values immediately.
